bus_arbiter_rr: RTL

//  Round-robin arbiter for the shared system bus (BUS_addr/BUS_data/BUS_req/BUS_ready/BUS_RW).

---
 rtl/bus_arbiter_rr.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_rr
//  Description : Round-robin arbiter for the shared system bus. It issues a
//                registered one-hot grant, holds the grant for the whole
//                ownership, and inserts turnaround cycles between owners. A
//                ready watchdog revokes an owner whose transfer stalls too long.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_rr #(
   parameter int N_MASTER   = 8,
   parameter int IDX_W      = 3,
   parameter int TIMEOUT    = 1024,
   parameter int TO_W       = 11,
   parameter int TURNAROUND = 1
) (
   input  logic                clk,
   input  logic                clr,
   input  logic [N_MASTER-1:0] DMA,
   input  logic                BUS_req,
   input  logic                BUS_ready,
   output logic [N_MASTER-1:0] grant,
   output logic [IDX_W-1:0]    owner,
   output logic                bus_busy,
   output logic                timeout,
   output logic [IDX_W-1:0]    err_owner
);

   localparam int                  TURN_W      = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
   localparam logic [TO_W-1:0]     C_WDOG_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [TURN_W-1:0]   C_TURN_LAST = TURN_W'(TURNAROUND - 1);
   localparam logic [N_MASTER-1:0] C_ONE       = N_MASTER'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_TURN  = 2'd2
   } state_t;

   state_t              r_state;
   logic [IDX_W-1:0]    r_last_ptr;
   logic [TO_W-1:0]     r_wdog;
   logic [TURN_W-1:0]   r_turn_cnt;
   logic [N_MASTER-1:0] r_lockout;

   logic [N_MASTER-1:0] w_elig;
   logic                w_found;
   logic [IDX_W-1:0]    w_pick;
   logic                w_stall;

   // A revoked master stays ineligible until it drops its request once.
   assign w_elig  = DMA & ~r_lockout;
   // Transfer in progress that the slave has not yet acknowledged.
   assign w_stall = BUS_req & ~BUS_ready;

   // Rotating search for the first eligible master after the last one served.
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_last_ptr;
      for (int i = 1; i <= N_MASTER; i++) begin
         if (!w_found && w_elig[IDX_W'((int'(r_last_ptr) + i) % N_MASTER)]) begin
            w_found = 1'b1;
            w_pick  = IDX_W'((int'(r_last_ptr) + i) % N_MASTER);
         end
      end
   end

   // Arbitration state machine with registered grant, status and watchdog.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state    <= S_IDLE;
         r_last_ptr <= IDX_W'(N_MASTER - 1);
         r_wdog     <= '0;
         r_turn_cnt <= '0;
         r_lockout  <= '0;
         grant      <= '0;
         owner      <= '0;
         bus_busy   <= 1'b0;
         timeout    <= 1'b0;
         err_owner  <= '0;
      end else begin
         timeout   <= 1'b0;
         r_lockout <= r_lockout & DMA;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  grant      <= C_ONE << w_pick;
                  owner      <= w_pick;
                  r_last_ptr <= w_pick;
                  bus_busy   <= 1'b1;
                  r_wdog     <= '0;
                  r_state    <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (w_stall) begin
                  if (r_wdog == C_WDOG_LAST) begin
                     // Dead slave: take the bus away and bar the owner from re-arbitrating.
                     grant      <= '0;
                     bus_busy   <= 1'b0;
                     timeout    <= 1'b1;
                     err_owner  <= owner;
                     r_lockout  <= (r_lockout & DMA) | (C_ONE << owner);
                     r_wdog     <= '0;
                     r_turn_cnt <= '0;
                     r_state    <= S_TURN;
                  end else begin
                     r_wdog <= r_wdog + TO_W'(1);
                  end
               end else begin
                  r_wdog <= '0;
                  // Release only once no transfer is in flight.
                  if (!DMA[owner] && !BUS_req) begin
                     grant      <= '0;
                     bus_busy   <= 1'b0;
                     r_turn_cnt <= '0;
                     r_state    <= S_TURN;
                  end
               end
            end
            S_TURN: begin
               if (r_turn_cnt == C_TURN_LAST) begin
                  r_state <= S_IDLE;
               end else begin
                  r_turn_cnt <= r_turn_cnt + TURN_W'(1);
               end
            end
            default: begin
               grant    <= '0;
               bus_busy <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
